mod_exp_ctrl: RTL and testbench
===============================

// Module: mod_exp_ctrl
// PURPOSE
//  Sequences the Montgomery multiplier (mon_prod) to compute M^e mod n by left-to-right square-and-multiply.
//  Host preloads x_bar = R mod n at addr 0 and M_bar at addr 2. This block issues one OPXX per exponent bit,
//  plus an OPXM per set bit, then a final OPX1 that converts the result out of Montgomery form (result at addr 0).
//  Sits between the host/top FSM and mon_prod. It owns mon_prod's start/op_code/mp_count; it never touches memory.
// PARAMETERS
//  EBITS      256  max exponent width processed
//  LOG_EBITS  8    log2(EBITS); sizes exp_len and mp_count
//  MP_COUNT   256  value driven on mp_count (multiplier iterations per op)
//  GUARD      272  cycles after reset before go is accepted (covers an in-flight mon_prod op, which has no reset)
// PORTS
//  clk         in   1            clock, rising edge
//  rst         in   1            async active-high reset
//  go          in   1            start request; accepted only when ready=1
//  exponent    in   EBITS        exponent e; latched on accept
//  exp_len     in   LOG_EBITS+1  number of low exponent bits to process; values >EBITS are clamped to EBITS
//  ready       out  1            IDLE and guard expired
//  busy        out  1            run in progress (accept cycle through DONE)
//  done        out  1            one-cycle pulse when the final OPX1 completes
//  ops_issued  out  16           mon_prod ops issued in the current/last run; cleared on accept
//  mp_start    out  1            one-cycle start pulse to mon_prod
//  mp_op_code  out  2            OPXX=0 / OPXM=1 / OPX1=2; held stable from issue until completion
//  mp_count    out  LOG_EBITS+1  constant MP_COUNT
//  mp_stop     in   1            mon_prod completion level (goes low the cycle after start, high when finished)
// BEHAVIOUR
//  Reset (async): state=IDLE; ready=0, busy=0, done=0, mp_start=0, mp_op_code=OPXX, ops_issued=0,
//   guard=GUARD, stop_q=1. mp_count=MP_COUNT always.
//  Guard: decrements once per cycle to 0. ready = (state==IDLE) && (guard==0).
//  Completion event: stop_rise = mp_stop & ~stop_q. stop_q <= mp_stop every cycle.
//   A level held high counts once. A stale high mp_stop never counts.
//  States:
//   IDLE      go&&ready -> latch e_reg = exponent << (EBITS-len), where len = min(exp_len,EBITS); bits_left=len;
//             ops_issued=0; busy=1. Go to OUT_ISSUE if len==0, else SQ_ISSUE. go when !ready: ignored.
//   SQ_ISSUE  mp_start=1, mp_op_code=OPXX, ops_issued++ -> SQ_WAIT
//   SQ_WAIT   on stop_rise: e_reg[EBITS-1] ? MUL_ISSUE : NEXT
//   MUL_ISSUE mp_start=1, mp_op_code=OPXM, ops_issued++ -> MUL_WAIT
//   MUL_WAIT  on stop_rise -> NEXT
//   NEXT      e_reg<<=1, bits_left--; go to OUT_ISSUE if bits_left was 1, else SQ_ISSUE
//   OUT_ISSUE mp_start=1, mp_op_code=OPX1, ops_issued++ -> OUT_WAIT
//   OUT_WAIT  on stop_rise -> DONE
//   DONE      done=1 (single cycle), busy=0 -> IDLE
//  mp_start is high exactly one cycle per op. No new op is issued before the previous stop_rise.
//  Ops per run = len + popcount(processed bits) + 1. Max = 2*EBITS+1 = 513, so 16-bit ops_issued never wraps.
//  Overhead per op = issue cycle + 1 edge-detect cycle (+1 NEXT per bit) on top of mon_prod latency.
//  go while busy: ignored; the latched exponent is unaffected. go in the DONE cycle: ignored. go on the cycle IDLE is re-entered: accepted if ready.
//  rst mid-run: immediate return to IDLE with all outputs at reset values. The run is abandoned (no done).
//   ready stays low for GUARD cycles. Memory contents are undefined; the host must reload.
//  len==0: single OPX1 (result = 1 mod n).
// STRUCTURE
//  Shared package mp_pkg: OPXX/OPXM/OPX1 constants (2-bit) and the state enum. mon_prod shall also use these constants.
//  Single module; the edge detector, guard counter and exponent shifter are inline. No sub-module needed.
// TESTING (mon_prod behavioural model: stop drops 1 cycle after start, rises 260 cycles later)
//  exponent=0b1011, exp_len=4 -> op sequence XX,XM,XX,XX,XM,XX,XM,X1; ops_issued=8; exactly one done pulse.
//  exp_len=0 -> single OPX1, then done; ops_issued=1.
//  exp_len=300, exponent=all ones -> clamped to 256; 513 ops; ops_issued=513.
//  go asserted every cycle while busy and during guard -> only the first go with ready=1 is accepted; ready rises GUARD cycles after rst release.
//  mp_stop held high before go and for 50 cycles after a completion -> no premature advance; each completion counted once.
//  rst asserted in MUL_WAIT -> mp_start/busy/done low in the same cycle, state IDLE. Then a full run with real mon_prod:
//   n=0xB (padded to 256b), M=3, e=5 -> addr 0 holds 3^5 mod 11 = 1.

Source files
------------

// File: rtl/mp_pkg.sv
// Shared Montgomery-multiplier definitions: op codes seen by mon_prod and the
// state encoding of the modular-exponentiation sequencer.
package mp_pkg;

  localparam logic [1:0] OPXX = 2'd0;
  localparam logic [1:0] OPXM = 2'd1;
  localparam logic [1:0] OPX1 = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SQ_ISSUE  = 4'd1,
    ST_SQ_WAIT   = 4'd2,
    ST_MUL_ISSUE = 4'd3,
    ST_MUL_WAIT  = 4'd4,
    ST_NEXT      = 4'd5,
    ST_OUT_ISSUE = 4'd6,
    ST_OUT_WAIT  = 4'd7,
    ST_DONE      = 4'd8
  } mx_state_t;

endpackage

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving mon_prod: one OPXX per
// exponent bit, one OPXM per set bit, then a final OPX1 out of Montgomery form.
module mod_exp_ctrl
  import mp_pkg::*;
#(
  parameter int EBITS     = 256,
  parameter int LOG_EBITS = 8,
  parameter int MP_COUNT  = 256,
  parameter int GUARD     = 272
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [EBITS-1:0]     exponent,
  input  logic [LOG_EBITS:0]   exp_len,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          ops_issued,
  output logic                 mp_start,
  output logic [1:0]           mp_op_code,
  output logic [LOG_EBITS:0]   mp_count,
  input  logic                 mp_stop
);

  localparam int LW = LOG_EBITS + 1;
  localparam int GW = $clog2(GUARD + 1);

  mx_state_t        r_state;
  logic [GW-1:0]    r_guard;
  logic             r_stop_q;
  logic [EBITS-1:0] r_e;
  logic [LW-1:0]    r_bits_left;
  logic             r_busy;
  logic             r_done;
  logic             r_mp_start;
  logic [1:0]       r_op;
  logic [15:0]      r_ops;

  logic [LW-1:0]    w_len;
  logic [LW-1:0]    w_shift;
  logic             w_ready;
  logic             w_stop_rise;

  // Oversized lengths clamp to EBITS; the processed bits are left-aligned so
  // the current bit is always the MSB of r_e.
  assign w_len       = (exp_len > LW'(EBITS)) ? LW'(EBITS) : exp_len;
  assign w_shift     = LW'(EBITS) - w_len;
  assign w_ready     = (r_state == ST_IDLE) && (r_guard == '0);
  // Only a fresh low-to-high edge counts, so a stale or held-high stop is ignored.
  assign w_stop_rise = mp_stop & ~r_stop_q;

  assign ready      = w_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign ops_issued = r_ops;
  assign mp_start   = r_mp_start;
  assign mp_op_code = r_op;
  assign mp_count   = LW'(MP_COUNT);

  // Sequencer FSM with guard counter, stop edge detector and exponent shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_guard     <= GW'(GUARD);
      r_stop_q    <= 1'b1;
      r_e         <= '0;
      r_bits_left <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mp_start  <= 1'b0;
      r_op        <= OPXX;
      r_ops       <= 16'd0;
    end else begin
      r_stop_q   <= mp_stop;
      r_mp_start <= 1'b0;
      r_done     <= 1'b0;
      if (r_guard != '0) begin
        r_guard <= r_guard - GW'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (go && w_ready) begin
            r_e         <= exponent << w_shift;
            r_bits_left <= w_len;
            r_ops       <= 16'd0;
            r_busy      <= 1'b1;
            r_state     <= (w_len == '0) ? ST_OUT_ISSUE : ST_SQ_ISSUE;
          end
        end
        ST_SQ_ISSUE: begin
          r_mp_start <= 1'b1;
          r_op       <= OPXX;
          r_ops      <= r_ops + 16'd1;
          r_state    <= ST_SQ_WAIT;
        end
        ST_SQ_WAIT: begin
          if (w_stop_rise) begin
            r_state <= r_e[EBITS-1] ? ST_MUL_ISSUE : ST_NEXT;
          end
        end
        ST_MUL_ISSUE: begin
          r_mp_start <= 1'b1;
          r_op       <= OPXM;
          r_ops      <= r_ops + 16'd1;
          r_state    <= ST_MUL_WAIT;
        end
        ST_MUL_WAIT: begin
          if (w_stop_rise) begin
            r_state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          r_e         <= {r_e[EBITS-2:0], 1'b0};
          r_bits_left <= r_bits_left - LW'(1);
          r_state     <= (r_bits_left == LW'(1)) ? ST_OUT_ISSUE : ST_SQ_ISSUE;
        end
        ST_OUT_ISSUE: begin
          r_mp_start <= 1'b1;
          r_op       <= OPX1;
          r_ops      <= r_ops + 16'd1;
          r_state    <= ST_OUT_WAIT;
        end
        ST_OUT_WAIT: begin
          if (w_stop_rise) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Scoreboard bench for mod_exp_ctrl with a behavioural mon_prod (timing plus
// small-modulus Montgomery arithmetic) and a square-and-multiply reference.
module tb_mod_exp_ctrl;
  import mp_pkg::*;

  localparam int EBITS = 256;
  localparam int GUARD = 272;

  logic         clk = 1'b0;
  logic         rst;
  logic         go;
  logic [255:0] exponent;
  logic [8:0]   exp_len;
  logic         ready, busy, done, mp_start;
  logic [15:0]  ops_issued;
  logic [1:0]   mp_op_code;
  logic [8:0]   mp_count;
  logic         mp_stop = 1'b1;

  int errors = 0;
  int checks = 0;
  int lat = 260;
  int op_q[$];
  int ops_q[$];
  int run_ops = 0;
  bit outstanding = 1'b0;
  logic prev_stop = 1'b1;
  int cnt = 0;
  longint n_mod = 11;
  longint x_val = 0, mbar_val = 0, rinv = 0, rmod = 1;

  mod_exp_ctrl dut (
    .clk(clk), .rst(rst), .go(go), .exponent(exponent), .exp_len(exp_len),
    .ready(ready), .busy(busy), .done(done), .ops_issued(ops_issued),
    .mp_start(mp_start), .mp_op_code(mp_op_code), .mp_count(mp_count),
    .mp_stop(mp_stop)
  );

  always #5 clk = ~clk;

  // mon_prod stand-in: stop drops the cycle after start and rises lat cycles later.
  always @(negedge clk) begin
    if (mp_start) begin
      mp_stop = 1'b0;
      cnt = lat;
      case (mp_op_code)
        2'd0:    x_val = (x_val * x_val % n_mod) * rinv % n_mod;
        2'd1:    x_val = (x_val * mbar_val % n_mod) * rinv % n_mod;
        default: x_val = x_val * rinv % n_mod;
      endcase
    end else if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) mp_stop = 1'b1;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expected ops on every start and expected op totals on done.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      outstanding = 1'b0;
      run_ops = 0;
    end else begin
      if (mp_stop && !prev_stop) outstanding = 1'b0;
      if (mp_start) begin
        chk("op_overlap", outstanding, 0);
        outstanding = 1'b1;
        if (op_q.size() == 0) begin
          chk("unexpected_op", 1, 0);
        end else begin
          chk("op_code", mp_op_code, op_q.pop_front());
          run_ops++;
          chk("ops_running", ops_issued, run_ops);
        end
      end
      if (done) begin
        if (ops_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("ops_issued", ops_issued, ops_q.pop_front());
        run_ops = 0;
      end
    end
    prev_stop = mp_stop;
  end

  // Reference: processed bits MSB first, square always, multiply on set bits.
  task automatic push_run(input logic [255:0] e, input int len_in);
    int len = (len_in > EBITS) ? EBITS : len_in;
    int pops = 0;
    for (int i = len - 1; i >= 0; i--) begin
      op_q.push_back(0);
      if (e[i]) begin
        op_q.push_back(1);
        pops++;
      end
    end
    op_q.push_back(2);
    ops_q.push_back(len + pops + 1);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 2000; i++) begin
      if (ready) return;
      @(negedge clk);
    end
    chk("ready_timeout", 0, 1);
  endtask

  task automatic do_run(input logic [255:0] e, input int len, input bit hold_go);
    int budget;
    wait_ready();
    exponent = e;
    exp_len = 9'(len);
    go = 1'b1;
    push_run(e, len);
    @(negedge clk);
    if (!hold_go) go = 1'b0;
    budget = 2000 + (2 * len + 2) * (lat + 6);
    for (int i = 0; i < budget; i++) begin
      if (done) return;
      if (hold_go) begin
        exponent = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        exp_len = 9'($urandom_range(0, 300));
      end
      @(negedge clk);
    end
    chk("done_timeout", 0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw_busy;
    longint expv;
    rst = 1'b1; go = 1'b0; exponent = '0; exp_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mp_start", mp_start, 0);
    chk("rst_op_code", mp_op_code, OPXX);
    chk("rst_ops", ops_issued, 0);
    chk("mp_count", mp_count, 256);

    // Guard: go held from release; only the first go with ready is accepted.
    exponent = 256'hB; exp_len = 9'd4; go = 1'b1;
    rst = 1'b0;
    n = 0; saw_busy = 1'b0;
    while (!ready && n < 400) begin
      @(negedge clk);
      n++;
      if (busy) saw_busy = 1'b1;
    end
    chk("guard_cycles", n, GUARD);
    chk("busy_in_guard", saw_busy, 0);
    push_run(256'hB, 4);
    @(negedge clk);
    chk("busy_after_go", busy, 1);
    for (int i = 0; i < 4000 && !done; i++) begin
      exponent = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      exp_len = 9'($urandom_range(0, 300));
      @(negedge clk);
    end
    chk("first_done", done, 1);
    go = 1'b0;
    @(negedge clk);
    chk("done_single_cycle", done, 0);

    lat = 4;
    do_run(256'h0, 0, 1'b0);
    do_run('1, 300, 1'b0);
    do_run(256'h0, 256, 1'b0);

    // Random runs, some back-to-back with go held into the re-entered IDLE cycle.
    for (int r = 0; r < 10; r++) begin
      lat = $urandom_range(1, 12);
      do_run({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
             ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 24),
             (r < 9) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    go = 1'b0;

    // Reset in MUL_WAIT abandons the run immediately.
    lat = 260;
    wait_ready();
    exponent = 256'h8; exp_len = 9'd4; go = 1'b1;
    push_run(256'h8, 4);
    @(negedge clk);
    go = 1'b0;
    n = 0;
    while (!(mp_start && mp_op_code == OPXM) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_mul", mp_op_code, OPXM);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_start", mp_start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", ready, 0);
    chk("midrst_ops", ops_issued, 0);
    op_q.delete();
    ops_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Full run with Montgomery arithmetic: 3^5 mod 11.
    rmod = 1;
    repeat (EBITS) rmod = rmod * 2 % n_mod;
    for (longint k = 1; k < n_mod; k++) if (rmod * k % n_mod == 1) rinv = k;
    x_val = rmod;
    mbar_val = 3 * rmod % n_mod;
    expv = 1;
    repeat (5) expv = expv * 3 % n_mod;
    do_run(256'h5, 3, 1'b0);
    repeat (3) @(negedge clk);
    chk("modexp_result", x_val, expv);
    chk("op_q_empty", op_q.size(), 0);
    chk("ops_q_empty", ops_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
